// File: rtl/control_sequencer_pkg.sv
// Shared widths, control-word field map, canned control words and phase/state codes.
package control_sequencer_pkg;

    localparam int unsigned IW = 32;
    localparam int unsigned CW = 33;
    localparam int unsigned DW = 64;

    // Control word field indices
    localparam int unsigned CwAluEn    = 32;
    localparam int unsigned CwAluBs    = 31;
    localparam int unsigned CwRfBEn    = 25;
    localparam int unsigned CwRfW      = 9;
    localparam int unsigned CwRamEn    = 8;
    localparam int unsigned CwRamW     = 7;
    localparam int unsigned CwPcEn     = 6;
    localparam int unsigned CwPcFsLo   = 4;
    localparam int unsigned CwPcIs     = 3;
    localparam int unsigned CwStatusLd = 2;

    // Canned words: idle is all zero; stall reads RAM with PC held; fetch reads RAM and steps PC+4.
    localparam logic [CW-1:0] CW_IDLE  = '0;
    localparam logic [CW-1:0] CW_STALL = CW'(1) << CwRamEn;
    localparam logic [CW-1:0] CW_FETCH = (CW'(1) << CwRamEn) | (CW'(1) << CwPcFsLo);

    typedef enum logic {
        PhFetch = 1'b0,
        PhExec  = 1'b1
    } phase_e;

    localparam logic [1:0] ST_0 = 2'b00;
    localparam logic [1:0] ST_1 = 2'b01;
    localparam logic [1:0] ST_2 = 2'b10;
    localparam logic [1:0] ST_3 = 2'b11;

endpackage

// File: rtl/control_sequencer_if.sv
// Bus bundle between the sequencer (master) and the surrounding control unit/datapath (slave).
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [DW-1:0] data_bus;
    logic          mem_ready;
    logic [CW-1:0] cw_in;
    logic [3:0]    alu_flags;
    logic          alu_zero;
    logic [IW-1:0] instr;
    logic [1:0]    state;
    logic [4:0]    status;
    logic [CW-1:0] cw_out;
    logic          fetching;

    modport master (
        input  data_bus, mem_ready, cw_in, alu_flags, alu_zero,
        output instr, state, status, cw_out, fetching
    );

    modport slave (
        output data_bus, mem_ready, cw_in, alu_flags, alu_zero,
        input  instr, state, status, cw_out, fetching
    );

endinterface

// File: rtl/control_sequencer_status_register.sv
// 4-bit {V,C,N,Z} flag register with load enable.
module control_sequencer_status_register (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       ld_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] flags_q;

    // Capture flags only when loading; async clear.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            flags_q <= 4'b0000;
        end else if (ld_i) begin
            flags_q <= d_i;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: owns IR, execute state, phase and flags; muxes the control word.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 clock_i,
    input  logic                 reset_ni,
    control_sequencer_if.master  bus
);

    phase_e        phase_q, phase_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cw;
    logic          fetching;
    logic          flags_ld;
    logic [3:0]    flags;
    logic          unused_bus_hi;

    // Only the low instruction-width bits of the bus feed the IR.
    assign unused_bus_hi = ^bus.data_bus[DW-1:IW];

    // Phase, IR and execute-state registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_q <= PhFetch;
            ir_q    <= '0;
            state_q <= ST_0;
        end else begin
            phase_q <= phase_d;
            ir_q    <= ir_d;
            state_q <= state_d;
        end
    end

    // Next-state and control-word selection; reset forces the word to idle so no write can commit.
    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        state_d  = state_q;
        cw       = CW_IDLE;
        fetching = 1'b0;
        flags_ld = 1'b0;
        unique case (phase_q)
            PhFetch: begin
                fetching = 1'b1;
                if (bus.mem_ready) begin
                    cw      = CW_FETCH;
                    ir_d    = bus.data_bus[IW-1:0];
                    state_d = ST_0;
                    phase_d = PhExec;
                end else begin
                    cw = CW_STALL;
                end
            end
            PhExec: begin
                cw       = bus.cw_in;
                state_d  = bus.cw_in[1:0];
                flags_ld = bus.cw_in[CwStatusLd];
                if (bus.cw_in[1:0] == ST_0) begin
                    phase_d = PhFetch;
                end
            end
            default: begin
                phase_d = PhFetch;
            end
        endcase
        if (!reset_ni) begin
            cw       = CW_IDLE;
            fetching = 1'b1;
            flags_ld = 1'b0;
        end
    end

    control_sequencer_status_register u_status_reg (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .ld_i     (flags_ld),
        .d_i      (bus.alu_flags),
        .q_o      (flags)
    );

    assign bus.instr    = ir_q;
    assign bus.state    = state_q;
    assign bus.status   = {bus.alu_zero, flags};
    assign bus.cw_out   = cw;
    assign bus.fetching = fetching;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus a hand-written mid-EXEC reset sequence.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          mr;
        logic [63:0]   db;
        logic [32:0]   cw_in;
        logic [3:0]    flags;
        logic          az;
        logic [32:0]   e_cw;
        logic          e_fetch;
        logic [31:0]   e_i;
        logic [1:0]    e_st;
        logic [4:0]    e_status;
    } vec_t;

    localparam logic [32:0] STALL = 33'h0_0000_0100;
    localparam logic [32:0] FETCH = 33'h0_0000_0110;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [32:0] e_cw, input logic e_fetch,
                             input logic [31:0] e_i, input logic [1:0] e_st,
                             input logic [4:0] e_status);
        check({tag, ".cw_out"}, 64'(bus.cw_out), 64'(e_cw));
        check({tag, ".fetching"}, 64'(bus.fetching), 64'(e_fetch));
        check({tag, ".I"}, 64'(bus.instr), 64'(e_i));
        check({tag, ".state"}, 64'(bus.state), 64'(e_st));
        check({tag, ".status"}, 64'(bus.status), 64'(e_status));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //           mr  data_bus                cw_in            flags   az    exp_cw           fe    exp_I         st     status
        vecs[0]  = '{1'b0, 64'h0000_0000_8B02_0020, 33'h0_0000_0000, 4'b0000, 1'b0, STALL,           1'b1, 32'h0,        2'b00, 5'b00000};
        vecs[1]  = '{1'b0, 64'h0000_0000_8B02_0020, 33'h0_0000_0004, 4'b1111, 1'b0, STALL,           1'b1, 32'h0,        2'b00, 5'b00000};
        vecs[2]  = '{1'b0, 64'h0000_0000_8B02_0020, 33'h0_0000_0000, 4'b0000, 1'b0, STALL,           1'b1, 32'h0,        2'b00, 5'b00000};
        vecs[3]  = '{1'b1, 64'hFFFF_0000_8B02_0020, 33'h0_0000_0000, 4'b0000, 1'b0, FETCH,           1'b1, 32'h0,        2'b00, 5'b00000};
        vecs[4]  = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0201, 4'b1111, 1'b0, 33'h0_0000_0201, 1'b0, 32'h8B020020, 2'b00, 5'b00000};
        vecs[5]  = '{1'b1, 64'h0000_0000_1111_1111, 33'h0_0000_0002, 4'b1111, 1'b0, 33'h0_0000_0002, 1'b0, 32'h8B020020, 2'b01, 5'b00000};
        vecs[6]  = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0004, 4'b1010, 1'b0, 33'h0_0000_0004, 1'b0, 32'h8B020020, 2'b10, 5'b00000};
        vecs[7]  = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0004, 4'b0101, 1'b0, STALL,           1'b1, 32'h8B020020, 2'b00, 5'b01010};
        vecs[8]  = '{1'b1, 64'h0000_0000_1234_5678, 33'h0_0000_0004, 4'b0101, 1'b0, FETCH,           1'b1, 32'h8B020020, 2'b00, 5'b01010};
        vecs[9]  = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0000, 4'b1111, 1'b1, 33'h0_0000_0000, 1'b0, 32'h12345678, 2'b00, 5'b11010};
        vecs[10] = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0000, 4'b1111, 1'b0, STALL,           1'b1, 32'h12345678, 2'b00, 5'b01010};
        vecs[11] = '{1'b1, 64'h0000_0000_DEAD_BEEF, 33'h0_0000_0000, 4'b1111, 1'b1, FETCH,           1'b1, 32'h12345678, 2'b00, 5'b11010};
        vecs[12] = '{1'b0, 64'h0000_0000_0000_0000, 33'h1_0000_0007, 4'b0011, 1'b0, 33'h1_0000_0007, 1'b0, 32'hDEADBEEF, 2'b00, 5'b01010};
        vecs[13] = '{1'b1, 64'h0000_0000_0000_0000, 33'h0_0000_0001, 4'b1100, 1'b0, 33'h0_0000_0001, 1'b0, 32'hDEADBEEF, 2'b11, 5'b00011};
        vecs[14] = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0000, 4'b1100, 1'b0, 33'h0_0000_0000, 1'b0, 32'hDEADBEEF, 2'b01, 5'b00011};
        vecs[15] = '{1'b0, 64'h0000_0000_0000_0000, 33'h0_0000_0000, 4'b1100, 1'b0, STALL,           1'b1, 32'hDEADBEEF, 2'b00, 5'b00011};

        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.data_bus  = '0;
        bus.cw_in     = '0;
        bus.alu_flags = 4'b0000;
        bus.alu_zero  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", 33'h0, 1'b1, 32'h0, 2'b00, 5'b00000);

        @(posedge clk);
        #1 rst_n = 1'b1;

        // Each row: drive after the edge, check mid-cycle, commit on the next edge.
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            bus.mem_ready = vecs[i].mr;
            bus.data_bus  = vecs[i].db;
            bus.cw_in     = vecs[i].cw_in;
            bus.alu_flags = vecs[i].flags;
            bus.alu_zero  = vecs[i].az;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_cw, vecs[i].e_fetch, vecs[i].e_i,
                      vecs[i].e_st, vecs[i].e_status);
        end

        // Fetch accept, then reset asserted in the middle of an EXEC cycle carrying writes.
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        bus.data_bus  = 64'h0000_0000_CAFE_F00D;
        bus.cw_in     = 33'h0_0000_0000;
        @(negedge clk);
        check("rst_seq.accept_cw", 64'(bus.cw_out), 64'(FETCH));

        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        bus.cw_in     = 33'h0_0000_0205;
        bus.alu_flags = 4'b1111;
        #1;
        check("rst_seq.exec_cw", 64'(bus.cw_out), 64'h205);
        check("rst_seq.exec_I", 64'(bus.instr), 64'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        check("rst_seq.cw_forced", 64'(bus.cw_out), 64'h0);
        check("rst_seq.fetching", 64'(bus.fetching), 64'h1);
        check("rst_seq.I_clr", 64'(bus.instr), 64'h0);
        check("rst_seq.state_clr", 64'(bus.state), 64'h0);

        @(posedge clk);
        #1;
        check("rst_seq.flags_held", 64'(bus.status[3:0]), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("rst_seq.release", STALL, 1'b1, 32'h0, 2'b00, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
